conv_mem_responder: RTL and testbench

Memory-side responder for the convolution engine's memory interfaces. It serves image reads on iaddr/idata and layer-memory writes and reads on cwr/caddr_wr/cdata_wr, crd/caddr_rd/cdata_rd, decoded by csel. It holds:
- the 4096-word image,
- two L0 banks, two L1 banks and one L2 bank.

A host port preloads the image before the run. A dump port streams any bank out after the run, for checking against golden data.

---
 rtl/conv_mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_conv_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the convolution engine: image ROM with host preload,
// five layer banks with combinational reads, run/done tracking and a bank dump stream.
module conv_mem_responder #(
  parameter int DW       = 20,
  parameter int AW       = 12,
  parameter int L0_DEPTH = 4096,
  parameter int L1_DEPTH = 1024,
  parameter int L2_DEPTH = 2048
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 busy,
  input  logic [AW-1:0]        iaddr,
  output logic signed [DW-1:0] idata,
  input  logic                 cwr,
  input  logic [AW-1:0]        caddr_wr,
  input  logic signed [DW-1:0] cdata_wr,
  input  logic                 crd,
  input  logic [AW-1:0]        caddr_rd,
  output logic signed [DW-1:0] cdata_rd,
  input  logic [2:0]           csel,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [AW-1:0]        ld_addr,
  input  logic signed [DW-1:0] ld_data,
  input  logic                 dump_start,
  input  logic [2:0]           dump_sel,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic signed [DW-1:0] dump_data,
  output logic [AW-1:0]        dump_addr,
  output logic                 dump_last,
  output logic                 done,
  output logic                 err_sel,
  output logic                 err_addr,
  output logic [15:0]          wr_count
);

  localparam int IMG_DEPTH = 1 << AW;
  localparam int L0_AW     = $clog2(L0_DEPTH);
  localparam int L1_AW     = $clog2(L1_DEPTH);
  localparam int L2_AW     = $clog2(L2_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE, DUMP} state_t;

  logic signed [DW-1:0] img_mem [IMG_DEPTH];
  logic signed [DW-1:0] l0a_mem [L0_DEPTH];
  logic signed [DW-1:0] l0b_mem [L0_DEPTH];
  logic signed [DW-1:0] l1a_mem [L1_DEPTH];
  logic signed [DW-1:0] l1b_mem [L1_DEPTH];
  logic signed [DW-1:0] l2_mem  [L2_DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] dump_addr_q, dump_addr_d;
  logic [2:0]    dump_sel_q, dump_sel_d;
  logic          err_sel_q, err_sel_d;
  logic          err_addr_q, err_addr_d;
  logic [15:0]   wr_cnt_q, wr_cnt_d;
  logic          clr_cnt, dump_sel_bad, wr_ok, rd_ok, ld_we, dump_end;
  logic [AW:0]   dump_depth;

  function automatic logic sel_legal(input logic [2:0] s);
    return (s >= 3'd1) && (s <= 3'd5);
  endfunction

  function automatic logic [AW:0] sel_depth(input logic [2:0] s);
    case (s)
      3'd1, 3'd2: return (AW+1)'(L0_DEPTH);
      3'd3, 3'd4: return (AW+1)'(L1_DEPTH);
      3'd5:       return (AW+1)'(L2_DEPTH);
      default:    return '0;
    endcase
  endfunction

  function automatic logic in_range(input logic [2:0] s, input logic [AW-1:0] a);
    return {1'b0, a} < sel_depth(s);
  endfunction

  assign wr_ok      = cwr && sel_legal(csel) && in_range(csel, caddr_wr);
  assign rd_ok      = crd && sel_legal(csel) && in_range(csel, caddr_rd);
  assign ld_we      = (state_q == IDLE) && ld_valid;
  assign dump_depth = sel_depth(dump_sel_q);
  assign dump_end   = {1'b0, dump_addr_q} == (dump_depth - (AW+1)'(1));

  // Memories carry no reset so their contents survive a reset mid-run.
  always_ff @(posedge clk) begin
    if (ld_we) img_mem[ld_addr] <= ld_data;
    if (wr_ok) begin
      case (csel)
        3'd1:    l0a_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'd2:    l0b_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'd3:    l1a_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'd4:    l1b_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'd5:    l2_mem[caddr_wr[L2_AW-1:0]]  <= cdata_wr;
        default: ;
      endcase
    end
  end

  assign idata = img_mem[iaddr];

  always_comb begin
    cdata_rd = '0;
    if (rd_ok) begin
      case (csel)
        3'd1:    cdata_rd = l0a_mem[caddr_rd[L0_AW-1:0]];
        3'd2:    cdata_rd = l0b_mem[caddr_rd[L0_AW-1:0]];
        3'd3:    cdata_rd = l1a_mem[caddr_rd[L1_AW-1:0]];
        3'd4:    cdata_rd = l1b_mem[caddr_rd[L1_AW-1:0]];
        3'd5:    cdata_rd = l2_mem[caddr_rd[L2_AW-1:0]];
        default: cdata_rd = '0;
      endcase
    end
  end

  always_comb begin
    dump_data = '0;
    if (state_q == DUMP) begin
      case (dump_sel_q)
        3'd1:    dump_data = l0a_mem[dump_addr_q[L0_AW-1:0]];
        3'd2:    dump_data = l0b_mem[dump_addr_q[L0_AW-1:0]];
        3'd3:    dump_data = l1a_mem[dump_addr_q[L1_AW-1:0]];
        3'd4:    dump_data = l1b_mem[dump_addr_q[L1_AW-1:0]];
        3'd5:    dump_data = l2_mem[dump_addr_q[L2_AW-1:0]];
        default: dump_data = '0;
      endcase
    end
  end

  // Entering RUN from any state starts a fresh write count; busy wins over dump traffic.
  always_comb begin
    state_d      = state_q;
    dump_addr_d  = dump_addr_q;
    dump_sel_d   = dump_sel_q;
    clr_cnt      = 1'b0;
    dump_sel_bad = 1'b0;
    case (state_q)
      IDLE: if (busy) begin state_d = RUN; clr_cnt = 1'b1; end
      RUN:  if (!busy) state_d = DONE;
      DONE: begin
        if (busy) begin
          state_d = RUN;
          clr_cnt = 1'b1;
        end else if (dump_start) begin
          if (sel_legal(dump_sel)) begin
            state_d     = DUMP;
            dump_sel_d  = dump_sel;
            dump_addr_d = '0;
          end else begin
            dump_sel_bad = 1'b1;
          end
        end
      end
      DUMP: begin
        if (busy) begin
          state_d = RUN;
          clr_cnt = 1'b1;
        end else if (dump_ready) begin
          if (dump_end) state_d = DONE;
          else          dump_addr_d = dump_addr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    err_sel_d  = err_sel_q | ((cwr | crd) & ~sel_legal(csel)) | dump_sel_bad;
    err_addr_d = err_addr_q
               | (cwr & sel_legal(csel) & ~in_range(csel, caddr_wr))
               | (crd & sel_legal(csel) & ~in_range(csel, caddr_rd));

    wr_cnt_d = wr_cnt_q;
    if (clr_cnt)                                          wr_cnt_d = '0;
    else if ((state_q == RUN) && wr_ok && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dump_addr_q <= '0;
      dump_sel_q  <= '0;
      err_sel_q   <= 1'b0;
      err_addr_q  <= 1'b0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      dump_addr_q <= dump_addr_d;
      dump_sel_q  <= dump_sel_d;
      err_sel_q   <= err_sel_d;
      err_addr_q  <= err_addr_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign ld_ready   = (state_q == IDLE);
  assign done       = (state_q == DONE) || (state_q == DUMP);
  assign dump_valid = (state_q == DUMP);
  assign dump_last  = (state_q == DUMP) && dump_end;
  assign dump_addr  = dump_addr_q;
  assign err_sel    = err_sel_q;
  assign err_addr   = err_addr_q;
  assign wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Randomized bench for conv_mem_responder against a behavioural memory/run model.
module tb_conv_mem_responder;

  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DONE = 2, PH_DUMP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy = 1'b0;
  logic [11:0] iaddr = '0;
  logic [19:0] idata;
  logic        cwr = 1'b0;
  logic [11:0] caddr_wr = '0;
  logic [19:0] cdata_wr = '0;
  logic        crd = 1'b0;
  logic [11:0] caddr_rd = '0;
  logic [19:0] cdata_rd;
  logic [2:0]  csel = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [11:0] ld_addr = '0;
  logic [19:0] ld_data = '0;
  logic        dump_start = 1'b0;
  logic [2:0]  dump_sel = '0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [19:0] dump_data;
  logic [11:0] dump_addr;
  logic        dump_last, done, err_sel, err_addr;
  logic [15:0] wr_count;

  int n_chk = 0;
  int n_fail = 0;

  conv_mem_responder dut (
    .clk(clk), .reset(reset), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .dump_start(dump_start), .dump_sel(dump_sel), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_addr(dump_addr),
    .dump_last(dump_last), .done(done), .err_sel(err_sel), .err_addr(err_addr),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int s);
    case (s)
      1, 2:    return 4096;
      3, 4:    return 1024;
      5:       return 2048;
      default: return 0;
    endcase
  endfunction

  function automatic int key(input int s, input int a);
    return s * 4096 + a;
  endfunction

  // Behavioural model: memories as sparse maps, run phase, dump cursor, flags.
  logic [19:0] img_m [int];
  logic [19:0] bank_m [int];
  int m_phase = PH_IDLE;
  int m_dsel = 0, m_daddr = 0, m_cnt = 0;
  bit m_esel = 0, m_eaddr = 0;

  always @(posedge clk or posedge reset) begin
    int d;
    if (reset) begin
      m_phase = PH_IDLE; m_daddr = 0; m_cnt = 0; m_esel = 0; m_eaddr = 0;
    end else begin
      if (m_phase == PH_IDLE && ld_valid) img_m[int'(ld_addr)] = ld_data;
      if (cwr) begin
        d = depth_of(int'(csel));
        if (d == 0) m_esel = 1;
        else if (int'(caddr_wr) >= d) m_eaddr = 1;
        else begin
          bank_m[key(int'(csel), int'(caddr_wr))] = cdata_wr;
          if (m_phase == PH_RUN && m_cnt < 65535) m_cnt++;
        end
      end
      if (crd) begin
        d = depth_of(int'(csel));
        if (d == 0) m_esel = 1;
        else if (int'(caddr_rd) >= d) m_eaddr = 1;
      end
      case (m_phase)
        PH_IDLE: if (busy) begin m_phase = PH_RUN; m_cnt = 0; end
        PH_RUN:  if (!busy) m_phase = PH_DONE;
        PH_DONE: begin
          if (busy) begin m_phase = PH_RUN; m_cnt = 0; end
          else if (dump_start) begin
            if (depth_of(int'(dump_sel)) > 0) begin
              m_phase = PH_DUMP; m_dsel = int'(dump_sel); m_daddr = 0;
            end else m_esel = 1;
          end
        end
        default: begin
          if (busy) begin m_phase = PH_RUN; m_cnt = 0; end
          else if (dump_ready) begin
            if (m_daddr == depth_of(m_dsel) - 1) m_phase = PH_DONE;
            else m_daddr++;
          end
        end
      endcase
    end
  end

  int beats[$];
  int lastq[$];
  int hold_bad = 0;
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [11:0] prev_a = '0;
  logic [19:0] prev_d = '0;

  always @(negedge clk) begin
    int d, k;
    if (img_m.exists(int'(iaddr))) chk("idata", idata, img_m[int'(iaddr)]);
    d = depth_of(int'(csel));
    if (crd && d > 0 && int'(caddr_rd) < d) begin
      k = key(int'(csel), int'(caddr_rd));
      if (bank_m.exists(k)) chk("cdata_rd", cdata_rd, bank_m[k]);
    end else chk("cdata_rd_zero", cdata_rd, 0);
    chk("ld_ready", ld_ready, (m_phase == PH_IDLE));
    chk("done", done, (m_phase >= PH_DONE));
    chk("dump_valid", dump_valid, (m_phase == PH_DUMP));
    chk("err_sel", err_sel, m_esel);
    chk("err_addr", err_addr, m_eaddr);
    chk("wr_count", wr_count, m_cnt);
    if (m_phase == PH_DUMP) begin
      chk("dump_addr", dump_addr, m_daddr);
      chk("dump_last", dump_last, (m_daddr == depth_of(m_dsel) - 1));
      k = key(m_dsel, m_daddr);
      if (bank_m.exists(k)) chk("dump_data", dump_data, bank_m[k]);
    end else chk("dump_last_idle", dump_last, 0);
    if (prev_v && !prev_r && dump_valid && (dump_addr !== prev_a || dump_data !== prev_d))
      hold_bad++;
    if (dump_valid && dump_ready) begin
      beats.push_back(int'(dump_addr));
      if (dump_last) lastq.push_back(int'(dump_addr));
    end
    prev_v = dump_valid; prev_r = dump_ready; prev_a = dump_addr; prev_d = dump_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int iq[$];
  logic [19:0] l2_7 = '0;

  initial begin
    bit fin;
    int bad;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_addr", dump_addr, 0);

    tick(); ld_valid = 1; ld_addr = 12'd0; ld_data = 20'h00100;
    iq.push_back(0);
    tick(); ld_addr = 12'd4095; ld_data = 20'hFFF00;
    iq.push_back(4095);
    for (int i = 0; i < 64; i++) begin
      tick(); ld_addr = 12'($urandom_range(1, 4094)); ld_data = 20'($urandom);
      iq.push_back(int'(ld_addr));
    end
    tick(); ld_valid = 0; iaddr = 12'd4095;
    @(negedge clk);
    chk("idata_4095", idata, 20'hFFF00);
    chk("ld_ready_idle", ld_ready, 1);
    tick(); iaddr = 12'd0;
    @(negedge clk);
    chk("idata_0", idata, 20'h00100);

    tick(); busy = 1;
    tick(); cwr = 1; csel = 3'd2; caddr_wr = 12'h3F0; cdata_wr = 20'h12345;
    tick(); cwr = 0; crd = 1; caddr_rd = 12'h3F0;
    ld_valid = 1; ld_addr = 12'd0; ld_data = 20'h55555;
    @(negedge clk);
    chk("rd_after_wr", cdata_rd, 20'h12345);
    chk("wr_count_1", wr_count, 1);
    chk("ld_ready_run", ld_ready, 0);
    tick(); crd = 0; ld_valid = 0; iaddr = 12'd0;
    @(negedge clk);
    chk("idata_run_unchanged", idata, 20'h00100);

    tick(); busy = 0;
    tick(); busy = 1;
    tick();
    @(negedge clk);
    chk("wr_count_cleared", wr_count, 0);
    for (int s = 1; s <= 5; s++) begin
      for (int a = 0; a < depth_of(s); a++) begin
        tick();
        cwr = 1; csel = 3'(s); caddr_wr = 12'(a); cdata_wr = 20'($urandom);
        if (s == 5 && a == 7) l2_7 = cdata_wr;
        crd = 1'($urandom_range(0, 1));
        caddr_rd = 12'($urandom_range(0, depth_of(s) - 1));
        iaddr = 12'(iq[$urandom_range(0, iq.size() - 1)]);
      end
    end
    tick(); cwr = 0; crd = 0; busy = 0;
    @(negedge clk);
    chk("wr_count_full", wr_count, 16'd12288);
    chk("done_before_fall", done, 0);
    tick();
    @(negedge clk);
    chk("done_after_run", done, 1);
    chk("err_sel_clean", err_sel, 0);
    chk("err_addr_clean", err_addr, 0);

    tick(); cwr = 1; csel = 3'd3; caddr_wr = 12'd1024; cdata_wr = 20'hABCDE;
    tick(); cwr = 0; crd = 1; csel = 3'd3; caddr_rd = 12'd0;
    @(negedge clk);
    chk("err_addr_set", err_addr, 1);
    tick(); csel = 3'd7;
    @(negedge clk);
    chk("illegal_sel_rd_zero", cdata_rd, 0);
    tick(); crd = 0; csel = 3'd0;
    @(negedge clk);
    chk("err_sel_set", err_sel, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("err_sel_sticky", err_sel, 1);
    chk("err_addr_sticky", err_addr, 1);

    beats.delete(); lastq.delete(); hold_bad = 0;
    tick(); dump_start = 1; dump_sel = 3'd5; dump_ready = 0;
    tick(); dump_start = 0;
    @(negedge clk);
    chk("dump_valid_rise", dump_valid, 1);
    fin = 0;
    for (int c = 0; c < 6000 && !fin; c++) begin
      tick();
      dump_ready = ~dump_ready;
      dump_start = (c == 101); dump_sel = (c == 101) ? 3'd1 : 3'd5;
      @(negedge clk);
      if (!dump_valid) fin = 1;
    end
    dump_start = 0; dump_ready = 0;
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL dump_timeout: got busy-dumping expected done within 6000 cycles");
    end
    chk("dump_beats", beats.size(), 2048);
    bad = 0;
    foreach (beats[i]) if (beats[i] != i) bad++;
    chk("dump_order", bad, 0);
    chk("dump_hold", hold_bad, 0);
    chk("dump_last_count", lastq.size(), 1);
    if (lastq.size() > 0) chk("dump_last_addr", lastq[0], 2047);
    chk("done_after_dump", done, 1);

    tick(); dump_ready = 1; dump_start = 1; dump_sel = 3'd5;
    tick(); dump_start = 0;
    fin = 0;
    for (int c = 0; c < 1000 && !fin; c++) begin
      @(negedge clk);
      if (dump_addr == 12'd500) fin = 1;
    end
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL dump_500_timeout: got no address 500 expected within 1000 cycles");
    end
    #2 reset = 1;
    @(negedge clk);
    chk("rst_mid_dump_valid", dump_valid, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_idle", ld_ready, 1);
    chk("rst_mid_err_sel", err_sel, 0);
    @(posedge clk);
    #1 reset = 0; dump_ready = 0;
    tick(); crd = 1; csel = 3'd5; caddr_rd = 12'd7;
    @(negedge clk);
    chk("l2_retained", cdata_rd, l2_7);
    for (int i = 0; i < 16; i++) begin
      tick(); caddr_rd = 12'($urandom_range(0, 2047));
    end

    tick(); crd = 0; busy = 1;
    tick(); busy = 0;
    tick(); dump_start = 1; dump_sel = 3'd0;
    tick(); dump_start = 0;
    @(negedge clk);
    chk("bad_dump_sel_err", err_sel, 1);
    chk("bad_dump_sel_idle", dump_valid, 0);
    tick(); dump_start = 1; dump_sel = 3'd3; dump_ready = 1;
    tick(); dump_start = 0;
    tick();
    tick(); busy = 1;
    tick();
    @(negedge clk);
    chk("abort_valid", dump_valid, 0);
    chk("abort_done", done, 0);
    tick(); busy = 0; dump_ready = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1000000");
    $fatal(1, "timeout");
  end

endmodule
